dram_arbiter: RTL

- **Function:** two-port arbiter and sequencer for the single-ported data RAM.
- **Requesters:** the CPU MEM stage (port 0, priority) and the DMA/debug loader (port 1, background).
- **Per-cycle behaviour:** grants at most one access per cycle and drives the RAM's chip-enable, write-enable, byte-select, address and write data. Read data is captured into per-port response registers.
- **CPU stall:** raised when the CPU is not granted.
- **Starvation guard:** port 1 is given a forced slot after a bounded wait.

---
 rtl/dram_arbiter_pkg.sv | 18 +
 rtl/dram_rsp_reg.sv | 36 +++
 rtl/dram_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared constants for the data-RAM arbiter: owner-state encodings, RAM strobe
// levels and response/counter widths.
package dram_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_CPU   = 2'd1;
  localparam logic [1:0] ARB_DMA   = 2'd2;
  localparam logic [1:0] ARB_FORCE = 2'd3;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam int RSP_W = 32;
  localparam int CNT_W = 8;

endpackage

// File: rtl/dram_rsp_reg.sv
// Per-port read-capture register: latches RAM read data on a granted read and
// pulses rvalid for one cycle afterwards.
module dram_rsp_reg
  import dram_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [RSP_W-1:0] ram_rdata,
  output logic             rvalid,
  output logic [RSP_W-1:0] rdata
);

  logic             rvalid_q, rvalid_d;
  logic [RSP_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = cap;
    rdata_d  = cap ? ram_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // A pulse already in flight when reset arrives is suppressed, not delivered.
  assign rvalid = rvalid_q & ~rst;
  assign rdata  = rdata_q;

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter for the single-ported data RAM: CPU (port 0) has priority,
// the DMA/loader (port 1) is guaranteed a slot after STARVE_LIMIT waiting cycles.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [AW-1:0]        m0_addr,
  input  logic [3:0]           m0_sel,
  input  logic [31:0]          m0_wdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [AW-1:0]        m1_addr,
  input  logic [3:0]           m1_sel,
  input  logic [31:0]          m1_wdata,
  output logic                 m0_gnt,
  output logic                 m1_gnt,
  output logic                 m0_rvalid,
  output logic                 m1_rvalid,
  output logic [31:0]          m0_rdata,
  output logic [31:0]          m1_rdata,
  output logic                 cpu_stall,
  output logic                 ram_ce,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [3:0]           ram_sel,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic [1:0]           dbg_state,
  output logic [CNT_W-1:0]     dbg_wait_cnt
);

  // Handshake: a requester holds req (and its fields) until it sees gnt in the
  // same cycle; the access happens in that cycle, so req&gnt is the transfer.

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             starve;

  always_comb begin
    starve  = m1_req && (wait_cnt_q == LIMIT);
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    state_d = ARB_IDLE;
    if (rst) begin
      state_d = ARB_IDLE;
    end else if (starve) begin
      m1_gnt  = 1'b1;
      state_d = ARB_FORCE;
    end else if (m0_req) begin
      m0_gnt  = 1'b1;
      state_d = ARB_CPU;
    end else if (m1_req) begin
      m1_gnt  = 1'b1;
      state_d = ARB_DMA;
    end
  end

  // Counts consecutive cycles port 1 has been left waiting; saturates at LIMIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m1_req || m1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    ram_ce    = CHIP_DISABLE;
    ram_we    = WRITE_DISABLE;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_ce    = CHIP_ENABLE;
      ram_we    = m0_we ? WRITE_ENABLE : WRITE_DISABLE;
      ram_addr  = m0_addr;
      ram_sel   = m0_sel;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_ce    = CHIP_ENABLE;
      ram_we    = m1_we ? WRITE_ENABLE : WRITE_DISABLE;
      ram_addr  = m1_addr;
      ram_sel   = m1_sel;
      ram_wdata = m1_wdata;
    end
  end

  assign cpu_stall    = m0_req & ~m0_gnt & ~rst;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;

  dram_rsp_reg u_rsp0 (
    .clk       (clk),
    .rst       (rst),
    .cap       (m0_gnt & ~m0_we),
    .ram_rdata (ram_rdata),
    .rvalid    (m0_rvalid),
    .rdata     (m0_rdata)
  );

  dram_rsp_reg u_rsp1 (
    .clk       (clk),
    .rst       (rst),
    .cap       (m1_gnt & ~m1_we),
    .ram_rdata (ram_rdata),
    .rvalid    (m1_rvalid),
    .rdata     (m1_rdata)
  );

endmodule
